// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_sequencer_pkg
//   Shared types for the program-counter sequencer.
//   - seqState_t : sequencer FSM states
//   - seq_stalls : true for states in which the datapath must not commit
// -----------------------------------------------------------------------------
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    RUN          = 3'd0,
    WAIT_PRESS   = 3'd1,
    WAIT_RELEASE = 3'd2,
    EXEC         = 3'd3,
    HALT         = 3'd4
  } seqState_t;

  // EXEC is deliberately not a stall state: it is the single cycle in which
  // the instruction that waited on the switch is allowed to commit.
  function automatic logic seq_stalls(input seqState_t s);
    return (s == WAIT_PRESS) || (s == WAIT_RELEASE) || (s == HALT);
  endfunction

endpackage

// File: rtl/pc_sequencer_switch_debouncer.sv
// -----------------------------------------------------------------------------
// switchDebouncer
//   Two-flop synchroniser followed by a level-stable counter. `stable` pulses
//   for one cycle on the clock edge at which the DEB_CYCLES-th consecutive
//   synchronised sample equal to `level` is taken; the counter restarts from
//   zero on that same edge.
//
// Ports
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   raw    in   asynchronous switch input
//   clear  in   hold the counter at zero (synchroniser keeps running)
//   level  in   level being waited for (1 = pressed, 0 = released)
//   stable out  one-cycle acceptance pulse
// -----------------------------------------------------------------------------
module switchDebouncer #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic clear,
  input  logic level,
  output logic stable
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] count;
  logic          match;

  assign match  = (sync2 == level);
  // The counter only ever needs to reach DEB_CYCLES-1: the sample that would
  // make it DEB_CYCLES is the one that fires `stable`.
  assign stable = !clear && match && (count == CW'(DEB_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source; blocking here would collapse the
  // synchroniser into a single flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      count <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (clear || stable || !match) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer in front of program memory. Supports increment,
//   absolute branch, HALT, and a stall that waits for a debounced press and
//   release of the demo switch before letting the current instruction commit
//   exactly once.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   pcInc        in   advance PC by one this cycle
//   branch       in   load branchTarget this cycle (beats pcInc)
//   branchTarget in   absolute branch destination
//   waitSwitch   in   current instruction waits for switch press + release
//   haltReq      in   current instruction is HALT
//   switchIn     in   raw asynchronous demo switch
//   addressOut   out  current PC
//   stalled      out  high in WAIT_PRESS, WAIT_RELEASE and HALT
//   halted       out  high in HALT
// -----------------------------------------------------------------------------
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int P_SIZE     = 5,
  parameter int DEB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pcInc,
  input  logic              branch,
  input  logic [P_SIZE-1:0] branchTarget,
  input  logic              waitSwitch,
  input  logic              haltReq,
  input  logic              switchIn,
  output logic [P_SIZE-1:0] addressOut,
  output logic              stalled,
  output logic              halted
);

  seqState_t         state;
  seqState_t         state_next;
  logic [P_SIZE-1:0] pc;
  logic [P_SIZE-1:0] pc_next;
  logic [P_SIZE-1:0] pc_step;
  logic              deb_clear;
  logic              deb_level;
  logic              deb_stable;

  // The counter only runs while waiting; leaving RUN therefore always starts
  // WAIT_PRESS from a zero count.
  assign deb_clear = !((state == WAIT_PRESS) || (state == WAIT_RELEASE));
  assign deb_level = (state == WAIT_PRESS);

  switchDebouncer #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debouncer (
    .clk   (clk),
    .reset (reset),
    .raw   (switchIn),
    .clear (deb_clear),
    .level (deb_level),
    .stable(deb_stable)
  );

  // Normal PC advance shared by RUN and EXEC; the add wraps naturally at
  // 2^P_SIZE.
  assign pc_step = branch ? branchTarget :
                   pcInc  ? pc + 1'b1    :
                            pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    unique case (state)
      RUN: begin
        if (haltReq) begin
          state_next = HALT;
        end else if (waitSwitch) begin
          state_next = WAIT_PRESS;
        end else begin
          pc_next = pc_step;
        end
      end
      WAIT_PRESS: begin
        if (deb_stable) state_next = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (deb_stable) state_next = EXEC;
      end
      EXEC: begin
        // waitSwitch/haltReq still describe the instruction that just waited;
        // honouring them here would re-stall it forever.
        state_next = RUN;
        pc_next    = pc_step;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  assign addressOut = pc;
  assign stalled    = seq_stalls(state);
  assign halted     = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed bench for pc_sequencer with P_SIZE=5 and DEB_CYCLES=4.
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
//   A switch level driven before edge s is first seen by the debounce
//   counter at edge s+2.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int P_SIZE     = 5;
  localparam int DEB_CYCLES = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              pcInc;
  logic              branch;
  logic [P_SIZE-1:0] branchTarget;
  logic              waitSwitch;
  logic              haltReq;
  logic              switchIn;
  logic [P_SIZE-1:0] addressOut;
  logic              stalled;
  logic              halted;

  int n_checks = 0;
  int n_fails  = 0;

  pc_sequencer #(
    .P_SIZE    (P_SIZE),
    .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pcInc       (pcInc),
    .branch      (branch),
    .branchTarget(branchTarget),
    .waitSwitch  (waitSwitch),
    .haltReq     (haltReq),
    .switchIn    (switchIn),
    .addressOut  (addressOut),
    .stalled     (stalled),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pcInc        = 1'b0;
    branch       = 1'b0;
    branchTarget = '0;
    waitSwitch   = 1'b0;
    haltReq      = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    switchIn = 1'b0;
    idle_inputs();
    step(2);
    check("rst_pc", 32'(addressOut), 0);
    check("rst_stalled", 32'(stalled), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_state", 32'(dut.state), 32'(RUN));
    reset = 1'b0;

    // Increment through the wrap: 1..31, 0, 1.
    pcInc = 1'b1;
    for (int i = 0; i < 33; i++) begin
      step(1);
      check("inc_pc", 32'(addressOut), (i + 1) % 32);
      check("inc_stalled", 32'(stalled), 0);
    end

    // 1 -> 3, then branch and pcInc together: branch wins.
    step(2);
    check("pre_branch_pc", 32'(addressOut), 3);
    branch       = 1'b1;
    branchTarget = 5'd17;
    step(1);
    check("branch_prio", 32'(addressOut), 17);

    // Branch to 5, then wait on the switch with pcInc pending.
    branchTarget = 5'd5;
    step(1);
    check("branch_5", 32'(addressOut), 5);
    branch     = 1'b0;
    waitSwitch = 1'b1;
    step(1);
    check("wait_enter_pc", 32'(addressOut), 5);
    check("wait_enter_stalled", 32'(stalled), 1);
    step(20);
    check("wait_low_pc", 32'(addressOut), 5);
    check("wait_low_stalled", 32'(stalled), 1);
    check("wait_low_state", 32'(dut.state), 32'(WAIT_PRESS));

    // Press: high seen at edges 3..6, accepted on the 6th edge.
    switchIn = 1'b1;
    step(5);
    check("press_early_state", 32'(dut.state), 32'(WAIT_PRESS));
    step(1);
    check("press_state", 32'(dut.state), 32'(WAIT_RELEASE));
    check("press_stalled", 32'(stalled), 1);
    check("press_pc", 32'(addressOut), 5);

    // Release: low seen at edges 9..12 counting from the press start.
    switchIn = 1'b0;
    step(5);
    check("release_early_stalled", 32'(stalled), 1);
    step(1);
    check("exec_state", 32'(dut.state), 32'(EXEC));
    check("exec_stalled", 32'(stalled), 0);
    check("exec_pc", 32'(addressOut), 5);
    waitSwitch = 1'b0;
    step(1);
    check("commit_pc", 32'(addressOut), 6);
    check("commit_state", 32'(dut.state), 32'(RUN));
    pcInc = 1'b0;
    step(1);
    check("post_commit_pc", 32'(addressOut), 6);
    check("post_commit_stalled", 32'(stalled), 0);

    // Bounce: 1,1,1,0 never gives four consecutive highs.
    waitSwitch = 1'b1;
    step(1);
    check("bounce_enter_stalled", 32'(stalled), 1);
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        switchIn = (k != 3);
        step(1);
      end
    end
    check("bounce_state", 32'(dut.state), 32'(WAIT_PRESS));
    check("bounce_pc", 32'(addressOut), 6);

    // Clean high: the last bounce low still clears the count at edge 2.
    switchIn = 1'b1;
    step(5);
    check("clean_early_state", 32'(dut.state), 32'(WAIT_PRESS));
    step(1);
    check("clean_state", 32'(dut.state), 32'(WAIT_RELEASE));

    // Let the release count start, then reset in WAIT_RELEASE.
    switchIn = 1'b0;
    step(3);
    check("rel_count", 32'(dut.u_debouncer.count), 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("mid_rst_state", 32'(dut.state), 32'(RUN));
    check("mid_rst_pc", 32'(addressOut), 0);
    check("mid_rst_stalled", 32'(stalled), 0);
    check("mid_rst_count", 32'(dut.u_debouncer.count), 0);
    waitSwitch = 1'b0;

    // HALT at PC=9 with pcInc also high.
    branch       = 1'b1;
    branchTarget = 5'd9;
    step(1);
    check("branch_9", 32'(addressOut), 9);
    branch  = 1'b0;
    pcInc   = 1'b1;
    haltReq = 1'b1;
    step(1);
    check("halt_pc", 32'(addressOut), 9);
    check("halt_halted", 32'(halted), 1);
    check("halt_stalled", 32'(stalled), 1);
    for (int i = 0; i < 50; i++) begin
      pcInc        = 1'($urandom_range(1, 0));
      branch       = 1'($urandom_range(1, 0));
      branchTarget = 5'($urandom_range(31, 0));
      waitSwitch   = 1'($urandom_range(1, 0));
      haltReq      = 1'($urandom_range(1, 0));
      switchIn     = 1'($urandom_range(1, 0));
      step(1);
      check("halt_hold_pc", 32'(addressOut), 9);
      check("halt_hold_halted", 32'(halted), 1);
      check("halt_hold_stalled", 32'(stalled), 1);
    end
    idle_inputs();
    switchIn = 1'b0;
    reset    = 1'b1;
    step(1);
    reset = 1'b0;
    check("halt_rst_pc", 32'(addressOut), 0);
    check("halt_rst_halted", 32'(halted), 0);
    check("halt_rst_stalled", 32'(stalled), 0);
    pcInc = 1'b1;
    step(1);
    check("after_halt_inc", 32'(addressOut), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
